// File: rtl/addsub_seq_n_pkg.sv
// rtl/addsub_seq_n_pkg.sv - shared types and parameter helpers for addsub_seq_n
`ifndef ADDSUB_SEQ_N_CHECK
`define ADDSUB_SEQ_N_CHECK(W, D) \
  if ((D) < 1 || (D) > (W) || ((W) % (D)) != 0) begin : g_cfg_check \
    $error("addsub_seq_n: WIDTH must be a positive multiple of DIGIT"); \
  end
`endif

package addsub_seq_n_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nslice(input int width, input int digit);
    return (digit > 0) ? width / digit : 1;
  endfunction

  // Slice counter never needs fewer than one bit, even for a single slice.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/addsub_seq_n_slice.sv
// rtl/addsub_seq_n_slice.sv - DIGIT-bit combinational ripple slice built from full_adder cells
module addsub_slice #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  assign cout     = c[DIGIT];
  // Carry into the slice MSB; on the last slice this feeds overflow detection.
  assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/addsub_seq_n.sv
// rtl/addsub_seq_n.sv - multi-cycle WIDTH-bit adder/subtractor iterating a DIGIT-bit slice
module addsub_seq_n
  import addsub_seq_n_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             M,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             V,
  output logic             Z
);

  localparam int NSLICE = nslice(WIDTH, DIGIT);
  localparam int CW     = cnt_width(NSLICE);
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  `ADDSUB_SEQ_N_CHECK(WIDTH, DIGIT)

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_r, b_r;
  logic [WIDTH-1:0] res_nx;
  logic [CW-1:0]    cnt;
  logic             carry_r;
  logic             accept, step, last;
  logic [DIGIT-1:0] sum;
  logic             cout, c_msb_in;

  addsub_slice #(.DIGIT(DIGIT)) u_slice (
    .a        (a_r[DIGIT-1:0]),
    .b        (b_r[DIGIT-1:0]),
    .cin      (carry_r),
    .s        (sum),
    .cout     (cout),
    .c_msb_in (c_msb_in)
  );

  // Result accumulates from the top: earlier slices drift down as new ones enter.
  if (NSLICE == 1) begin : g_one
    assign res_nx = sum;
  end else begin : g_many
    logic [WIDTH-DIGIT-1:0] res_r;

    assign res_nx = {sum, res_r};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        res_r <= '0;
      end else if (step) begin
        res_r <= res_nx[WIDTH-1:DIGIT];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    accept   = 1'b0;
    step     = 1'b0;
    last     = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST) begin
          last     = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1: invert B at capture and seed the carry with M.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r       <= '0;
      b_r       <= '0;
      carry_r   <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      S         <= '0;
      C         <= 1'b0;
      V         <= 1'b0;
      Z         <= 1'b0;
    end else begin
      if (accept) begin
        a_r     <= A;
        b_r     <= B ^ {WIDTH{M}};
        carry_r <= M;
        cnt     <= '0;
      end else if (step) begin
        a_r     <= a_r >> DIGIT;
        b_r     <= b_r >> DIGIT;
        carry_r <= cout;
        cnt     <= cnt + CW'(1);
      end

      if (last) begin
        S         <= res_nx;
        C         <= cout;
        V         <= c_msb_in ^ cout;
        Z         <= (res_nx == '0);
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_addsub_seq_n.sv
// tb/tb_addsub_seq_n.sv - self-checking bench for addsub_seq_n in three width/digit configurations
module tb_addsub_seq_n;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance 0: W16/D4, instance 1: W16/D16, instance 2: W8/D1.
  logic        iv[3];
  logic [15:0] av[3];
  logic [15:0] bv[3];
  logic        mv[3];
  logic        orv[3];
  wire         ir0, ir1, ir2, ov0, ov1, ov2;
  wire         c0, c1, c2, v0, v1, v2, z0, z1, z2;
  wire  [15:0] s0, s1;
  wire  [7:0]  s2;

  int total = 0;
  int bad   = 0;

  addsub_seq_n #(.WIDTH(16), .DIGIT(4)) u_w16d4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0), .A(av[0]), .B(bv[0]), .M(mv[0]),
    .out_valid(ov0), .out_ready(orv[0]), .S(s0), .C(c0), .V(v0), .Z(z0));

  addsub_seq_n #(.WIDTH(16), .DIGIT(16)) u_w16d16 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1), .A(av[1]), .B(bv[1]), .M(mv[1]),
    .out_valid(ov1), .out_ready(orv[1]), .S(s1), .C(c1), .V(v1), .Z(z1));

  addsub_seq_n #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir2), .A(av[2][7:0]), .B(bv[2][7:0]), .M(mv[2]),
    .out_valid(ov2), .out_ready(orv[2]), .S(s2), .C(c2), .V(v2), .Z(z2));

  // {in_ready, out_valid, S[15:0], C, V, Z}
  function automatic logic [20:0] outs(input int k);
    case (k)
      0:       return {ir0, ov0, s0, c0, v0, z0};
      1:       return {ir1, ov1, s1, c1, v1, z1};
      default: return {ir2, ov2, 8'h00, s2, c2, v2, z2};
    endcase
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic logic [18:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input logic m);
    longint mod_v, half, ua, ub, sa, sb, ur, sr, s;
    logic   c, v;
    mod_v = longint'(1) << w;
    half  = mod_v / 2;
    ua    = longint'(a);
    ub    = longint'(b);
    sa    = (ua >= half) ? ua - mod_v : ua;
    sb    = (ub >= half) ? ub - mod_v : ub;
    ur    = m ? ua - ub : ua + ub;
    sr    = m ? sa - sb : sa + sb;
    s     = ((ur % mod_v) + mod_v) % mod_v;
    c     = m ? (ua >= ub) : (ur >= mod_v);
    v     = (sr >= half) || (sr < -half);
    return {16'(s), c, v, (s == 0)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Issue one operation; returns outputs sampled in the first out_valid cycle and the latency.
  task automatic do_op(input int k, input logic [15:0] a, input logic [15:0] b, input logic m,
                       output logic [20:0] o, output int lat);
    int guard = 0;
    o = outs(k);
    while (!o[20] && guard < 40) begin
      @(posedge clk); #1;
      guard++;
      o = outs(k);
    end
    iv[k] = 1'b1;
    av[k] = a;
    bv[k] = b;
    mv[k] = m;
    @(posedge clk); #1;
    iv[k] = 1'b0;
    av[k] = 16'($urandom);
    bv[k] = 16'($urandom);
    mv[k] = 1'($urandom);
    lat = 0;
    o = outs(k);
    while (!o[19] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      o = outs(k);
    end
    if (!o[19]) chk("out_valid_timeout", 32'(o[19]), 32'd1);
    if (orv[k]) begin
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    int          k;
    logic [15:0] a;
    logic [15:0] b;
    logic        m;
    logic [15:0] s;
    logic        c;
    logic        v;
    logic        z;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [20:0] o, o2;
    logic [15:0] ra, rb, mask;
    logic        rm;
    int          lat;
    int          wd[3]  = '{16, 16, 8};
    int          lats[3] = '{4, 1, 8};

    tbl.push_back('{0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, 4});
    tbl.push_back('{0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 4});
    tbl.push_back('{0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 4});
    tbl.push_back('{0, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 4});
    tbl.push_back('{0, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 4});
    tbl.push_back('{0, 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 4});
    tbl.push_back('{1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1});
    tbl.push_back('{1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1});
    tbl.push_back('{2, 16'h007F, 16'h0001, 1'b0, 16'h0080, 1'b0, 1'b1, 1'b0, 8});
    tbl.push_back('{2, 16'h0000, 16'h0001, 1'b1, 16'h00FF, 1'b0, 1'b0, 1'b0, 8});
    tbl.push_back('{2, 16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8});

    for (int k = 0; k < 3; k++) begin
      iv[k]  = 1'b0;
      av[k]  = '0;
      bv[k]  = '0;
      mv[k]  = 1'b0;
      orv[k] = 1'b1;
    end
    rst = 1'b1;
    #12;
    for (int k = 0; k < 3; k++) chk($sformatf("reset_state_%0d", k), 32'(outs(k)), 32'h100000);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      do_op(tbl[i].k, tbl[i].a, tbl[i].b, tbl[i].m, o, lat);
      chk($sformatf("vec%0d_result", i), 32'(o[18:0]), 32'({tbl[i].s, tbl[i].c, tbl[i].v, tbl[i].z}));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
      o2 = outs(tbl[i].k);
      chk($sformatf("vec%0d_handshake", i), 32'(o2[20:19]), 32'b10);
    end

    // Backpressure: result and flags hold, no new operand accepted while in DONE.
    orv[0] = 1'b0;
    do_op(0, 16'hA5A5, 16'h1111, 1'b0, o, lat);
    chk("bp_result", 32'(o[18:0]), 32'(model(16, 16'hA5A5, 16'h1111, 1'b0)));
    for (int c = 0; c < 5; c++) begin
      iv[0] = (c % 2 == 0);
      av[0] = 16'h0001;
      bv[0] = 16'h0001;
      @(posedge clk); #1;
      chk($sformatf("bp_hold_%0d", c), 32'(outs(0)), 32'(o));
    end
    iv[0]  = 1'b0;
    orv[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", 32'(outs(0) >> 19), 32'b10);
    repeat (6) @(posedge clk);
    #1;
    chk("bp_no_accept", 32'(outs(0) >> 19), 32'b10);

    // Asynchronous reset during the second RUN cycle discards the operation.
    iv[0] = 1'b1;
    av[0] = 16'h0F0F;
    bv[0] = 16'h0101;
    mv[0] = 1'b0;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_run", 32'(outs(0)), 32'h100000);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_no_result", 32'(outs(0) >> 19), 32'b10);
    do_op(0, 16'h0001, 16'h0001, 1'b0, o, lat);
    chk("rst_fresh_op", 32'(o[18:0]), 32'({16'h0002, 1'b0, 1'b0, 1'b0}));

    for (int k = 0; k < 3; k++) begin
      mask = (wd[k] == 16) ? 16'hFFFF : 16'h00FF;
      for (int i = 0; i < 1000; i++) begin
        ra = 16'($urandom) & mask;
        rb = 16'($urandom) & mask;
        rm = 1'($urandom);
        if (i == 0) begin
          ra = mask;
          rb = mask;
        end
        do_op(k, ra, rb, rm, o, lat);
        chk($sformatf("rand_k%0d_%h_%h_m%0d", k, ra, rb, rm), 32'(o[18:0]), 32'(model(wd[k], ra, rb, rm)));
        chk($sformatf("rand_lat_k%0d", k), 32'(lat), 32'(lats[k]));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/addsub_seq_n.md
# addsub_seq_n

Parametrised, multi-cycle signed/unsigned adder-subtractor: the next generation of the 4-bit ripple adder-subtractor. It computes A+B or A−B for a WIDTH-bit operand pair by iterating a DIGIT-bit ripple slice over WIDTH/DIGIT cycles, with a registered carry between slices. Operands enter and results leave through valid/ready handshakes, and the result carries carry/borrow, signed-overflow and zero flags. It sits between an operand source, such as a register file or sequencer, and any result consumer that may apply backpressure.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT, else elaboration error
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH; NSLICE = WIDTH/DIGIT
- clk  in  1  sole clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  operand set valid
- in_ready  out  1  block can accept operands
- A  in  WIDTH  minuend/augend
- B  in  WIDTH  subtrahend/addend
- M  in  1  mode: 0 = add, 1 = subtract (A + ~B + 1)
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  consumer accepts result
- S  out  WIDTH  result, modulo 2^WIDTH
- C  out  1  carry out of bit WIDTH−1; in subtract mode, 1 = no borrow (A ≥ B unsigned)
- V  out  1  two's-complement overflow
- Z  out  1  S == 0

## Operation
- States: IDLE, RUN, DONE. One clock; reset is asynchronous and active-high.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, latch A, B⊕{WIDTH{M}} and M. Clear the slice counter. Load the carry register with M. Go to RUN.
- RUN:
  - in_ready = 0.
  - Each cycle, add the low DIGIT bits of the operand registers plus the carry register. Shift the sum slice into the top of the result register. Shift both operand registers right by DIGIT. Register the slice carry-out.
  - Increment the counter. After NSLICE RUN cycles, go to DONE.
- On the final slice, V = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1. C = final carry-out.
- DONE:
  - out_valid = 1. S, C, V and Z are stable and registered.
  - On out_valid & out_ready, go to IDLE. The next operand set can be accepted no earlier than the following cycle.
- In IDLE and RUN, S/C/V/Z hold the last delivered result (0 after reset). Consumers may sample them only while out_valid = 1.
- Inputs A/B/M are ignored except at the accept edge. Changes on them during RUN have no effect.
- Reset values: state IDLE, in_ready 1, out_valid 0, S 0, C 0, V 0, Z 0, counter 0, carry register 0.
- Reset asserted mid-RUN or in DONE: the operation is discarded, no result is delivered, and all outputs return to reset values immediately.
- NSLICE = 1 (DIGIT = WIDTH) is legal: one RUN cycle.

## Timing
- Accept at edge t0. RUN occupies edges t0+1 … t0+NSLICE. out_valid rises after edge t0+NSLICE, so latency is NSLICE cycles from the accept edge.
- Minimum initiation interval: NSLICE + 2 cycles (accept, NSLICE RUN, one DONE handshake cycle with out_ready held high).
- out_valid, S, C, V and Z are registered outputs with no combinational path from inputs.
- in_ready is a decode of the state register only and does not depend on out_ready.
- Critical path: one DIGIT-bit ripple plus carry register setup.

## Structure
- Shared package/header holds:
  - state encodings IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2
  - the NSLICE derivation
  - the WIDTH%DIGIT legality check macro
- Sub-module `addsub_slice`:
  - combinational DIGIT-bit ripple built from the team's existing full_adder cells
  - ports: a[DIGIT], b[DIGIT], cin → s[DIGIT], cout, c_msb_in (carry into the slice MSB, used for V)
- Top level holds the FSM, operand/result shift registers, carry register, counter and flag logic.

## Test plan
WIDTH=16, DIGIT=4 unless noted.
- Add 0x1234 + 0x0FFF, M=0, out_ready=1 → S=0x2233, C=0, V=0, Z=0; out_valid exactly 4 cycles after the accept edge.
- Add 0xFFFF + 0x0001 → S=0x0000, C=1, V=0, Z=1. Add 0x7FFF + 0x0001 → S=0x8000, C=0, V=1, Z=0.
- Subtract, M=1:
  - 0x0005 − 0x0007 → S=0xFFFE, C=0, V=0.
  - 0x8000 − 0x0001 → S=0x7FFF, C=1, V=1.
  - 0x1234 − 0x1234 → S=0, C=1, Z=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE → S/flags stable, out_valid stays 1, in_ready stays 0, and an in_valid pulse is not accepted.
  - Release out_ready → one handshake, then IDLE.
- Reset mid-op: assert rst during RUN cycle 2 → out_valid 0, S 0 immediately. After deassert, in_ready=1 and a fresh 0x0001+0x0001 yields S=0x0002.
- Parameter sweep: DIGIT=16, WIDTH=16 (latency 1) and DIGIT=1, WIDTH=8 (latency 8). 1000 random operand/mode pairs per configuration checked against a behavioural model for S/C/V/Z.
